// File: rtl/ascii_ctrl_pkg.sv
// Shared types and constant tables for the ASCII-art filter run-time controller.
package ascii_ctrl_pkg;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      ASCII = 2'd1,
      DEMO  = 2'd2
   } mode_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Palette index: 0 green, 1 amber, 2 mono, 3 cyan.
   localparam rgb444_t PALETTE_FG [0:3] = '{
      '{4'h0, 4'hF, 4'h0},
      '{4'hF, 4'hA, 4'h0},
      '{4'hF, 4'hF, 4'hF},
      '{4'h0, 4'hF, 4'hF}
   };

   localparam rgb444_t PALETTE_BG [0:3] = '{
      '{4'h0, 4'h1, 4'h0},
      '{4'h1, 4'h1, 4'h0},
      '{4'h0, 4'h0, 4'h0},
      '{4'h0, 4'h1, 4'h1}
   };

   // Mode sequence PASS -> ASCII -> DEMO -> PASS.
   function automatic mode_t mode_succ(input mode_t m);
      case (m)
         PASS:    return ASCII;
         ASCII:   return DEMO;
         default: return PASS;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and single-cycle press pulse.
// The press pulse is asserted in the cycle in which the stable level is about to flip 0->1.
module button_debounce
   import ascii_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          flip;

   // Counter runs only while the synchronised level differs from the stable level;
   // any return to the stable level restarts it.
   always_comb begin
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      flip     = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            flip     = 1'b1;
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press = flip & sync2_q;
   end

   // Synchroniser and stable level reset to "pressed" so a button held through reset
   // must be released before it can produce a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ascii_filter_ctrl.sv
// Run-time controller for the ASCII-art video filter: debounced mode/palette buttons,
// changes held pending and committed only on frame_start, DEMO-mode palette auto-step.
module ascii_filter_ctrl
   import ascii_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250_000,
   parameter int AUTO_FRAMES     = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_color,
   input  logic       frame_start,
   output logic [1:0] mode,
   output logic       filter_en,
   output logic [3:0] fg_r,
   output logic [3:0] fg_g,
   output logic [3:0] fg_b,
   output logic [3:0] bg_r,
   output logic [3:0] bg_g,
   output logic [3:0] bg_b,
   output logic       pending
);

   localparam int FCW = $clog2(AUTO_FRAMES + 1);

   logic           mode_press, color_press;
   mode_t          mode_q, mode_d;
   mode_t          mode_next_q, mode_next_d;
   logic           mode_pend_q, mode_pend_d;
   logic [1:0]     pal_q, pal_d;
   logic [1:0]     pal_next_q, pal_next_d;
   logic           pal_pend_q, pal_pend_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   mode_t          eff_mode;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_mode),
      .press   (mode_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_color (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_color),
      .press   (color_press)
   );

   // Next-state: latch at most one pending step per setting, commit everything on frame_start.
   always_comb begin
      mode_d      = mode_q;
      mode_next_d = mode_next_q;
      mode_pend_d = mode_pend_q;
      pal_d       = pal_q;
      pal_next_d  = pal_next_q;
      pal_pend_d  = pal_pend_q;
      frame_cnt_d = frame_cnt_q;
      eff_mode    = mode_pend_q ? mode_next_q : mode_q;

      if (mode_press && !mode_pend_q) begin
         mode_next_d = mode_succ(mode_q);
         mode_pend_d = 1'b1;
      end
      if (color_press && !pal_pend_q && (eff_mode != PASS)) begin
         pal_next_d = pal_q + 2'd1;
         pal_pend_d = 1'b1;
      end

      if (frame_start) begin
         if (mode_pend_d) mode_d = mode_next_d;
         if (pal_pend_d)  pal_d  = pal_next_d;
         // A manual palette commit in DEMO takes precedence over the auto-step.
         if (mode_d != mode_q) begin
            frame_cnt_d = '0;
         end else if (mode_q == DEMO) begin
            if (pal_pend_d) begin
               frame_cnt_d = '0;
            end else if (frame_cnt_q == FCW'(AUTO_FRAMES - 1)) begin
               pal_d       = pal_q + 2'd1;
               frame_cnt_d = '0;
            end else begin
               frame_cnt_d = frame_cnt_q + FCW'(1);
            end
         end
         mode_pend_d = 1'b0;
         pal_pend_d  = 1'b0;
      end
   end

   // State register: committed mode is the FSM state, the rest is pending/palette bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q      <= PASS;
         mode_next_q <= PASS;
         mode_pend_q <= 1'b0;
         pal_q       <= 2'd0;
         pal_next_q  <= 2'd0;
         pal_pend_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         mode_q      <= mode_d;
         mode_next_q <= mode_next_d;
         mode_pend_q <= mode_pend_d;
         pal_q       <= pal_d;
         pal_next_q  <= pal_next_d;
         pal_pend_q  <= pal_pend_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Outputs are plain decodes of the registered state.
   always_comb begin
      mode      = mode_q;
      filter_en = (mode_q != PASS);
      fg_r      = PALETTE_FG[pal_q].r;
      fg_g      = PALETTE_FG[pal_q].g;
      fg_b      = PALETTE_FG[pal_q].b;
      bg_r      = PALETTE_BG[pal_q].r;
      bg_g      = PALETTE_BG[pal_q].g;
      bg_b      = PALETTE_BG[pal_q].b;
      pending   = mode_pend_q | pal_pend_q;
   end

endmodule

// File: tb/tb_ascii_filter_ctrl.sv
// Self-checking bench for ascii_filter_ctrl with DEBOUNCE_CYCLES=4, AUTO_FRAMES=3.
module tb_ascii_filter_ctrl;

   localparam int DB   = 4;
   localparam int AUTO = 3;

   localparam logic [11:0] PFG [0:3] = '{12'h0F0, 12'hFA0, 12'hFFF, 12'h0FF};
   localparam logic [11:0] PBG [0:3] = '{12'h010, 12'h110, 12'h000, 12'h011};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_color = 1'b0;
   logic       frame_start = 1'b0;
   logic [1:0] mode;
   logic       filter_en;
   logic [3:0] fg_r, fg_g, fg_b, bg_r, bg_g, bg_b;
   logic       pending;

   int errors = 0;
   int checks = 0;

   ascii_filter_ctrl #(.DEBOUNCE_CYCLES(DB), .AUTO_FRAMES(AUTO)) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_mode    (btn_mode),
      .btn_color   (btn_color),
      .frame_start (frame_start),
      .mode        (mode),
      .filter_en   (filter_en),
      .fg_r        (fg_r),
      .fg_g        (fg_g),
      .fg_b        (fg_b),
      .bg_r        (bg_r),
      .bg_g        (bg_g),
      .bg_b        (bg_b),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   // Behavioural model: raw samples per edge, press when the synchronised level
   // (raw delayed two edges) has been high for DB cycles while the stable level is low.
   bit rq_m[$];
   bit rq_c[$];
   bit st_m, st_c;
   int m_mode, m_mnext, m_pal, m_pnext, m_fcnt;
   bit m_mpend, m_ppend;

   function automatic bit win_all(input bit q[$], input bit v);
      int n = q.size();
      for (int i = n - 2 - DB; i <= n - 3; i++)
         if (q[i] != v) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      bit pm, pc;
      int eff, old;
      bit manual;
      if (reset) begin
         rq_m.delete();
         rq_c.delete();
         for (int i = 0; i < DB + 2; i++) begin
            rq_m.push_back(1'b1);
            rq_c.push_back(1'b1);
         end
         st_m = 1'b1; st_c = 1'b1;
         m_mode = 0; m_mnext = 0; m_pal = 0; m_pnext = 0; m_fcnt = 0;
         m_mpend = 1'b0; m_ppend = 1'b0;
         return;
      end
      rq_m.push_back(btn_mode);
      rq_c.push_back(btn_color);
      if (rq_m.size() > 16) void'(rq_m.pop_front());
      if (rq_c.size() > 16) void'(rq_c.pop_front());
      pm = 1'b0; pc = 1'b0;
      if (win_all(rq_m, !st_m)) begin pm = !st_m; st_m = !st_m; end
      if (win_all(rq_c, !st_c)) begin pc = !st_c; st_c = !st_c; end

      eff = m_mpend ? m_mnext : m_mode;
      if (pm && !m_mpend) begin m_mnext = (m_mode + 1) % 3; m_mpend = 1'b1; end
      if (pc && !m_ppend && eff != 0) begin m_pnext = (m_pal + 1) % 4; m_ppend = 1'b1; end
      if (frame_start) begin
         old    = m_mode;
         manual = m_ppend;
         if (m_mpend) m_mode = m_mnext;
         if (m_ppend) m_pal = m_pnext;
         if (m_mode != old) m_fcnt = 0;
         else if (old == 2) begin
            if (manual) m_fcnt = 0;
            else if (m_fcnt == AUTO - 1) begin m_pal = (m_pal + 1) % 4; m_fcnt = 0; end
            else m_fcnt++;
         end
         m_mpend = 1'b0;
         m_ppend = 1'b0;
      end
   endtask

   task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: advance model at the edge, then compare the full output word.
   task automatic tick(input int n = 1);
      logic [27:0] act, exp;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_step();
         #1;
         act = {mode, filter_en, fg_r, fg_g, fg_b, bg_r, bg_g, bg_b, pending};
         exp = {m_mode[1:0], (m_mode != 0), PFG[m_pal], PBG[m_pal], (m_mpend | m_ppend)};
         chk("cycle_model", act, exp);
      end
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic press_mode();
      btn_mode = 1'b1; tick(8);
      btn_mode = 1'b0; tick(8);
   endtask

   task automatic press_color();
      btn_color = 1'b1; tick(8);
      btn_color = 1'b0; tick(8);
   endtask

   initial begin
      tick(3);
      chk("reset_mode", 28'(mode), 28'd0);
      chk("reset_colours", {fg_r, fg_g, fg_b, bg_r, bg_g, bg_b}, 28'h0F0010);
      chk("reset_pending", 28'(pending), 28'd0);
      reset = 1'b0;
      tick();

      // Glitch shorter than the debounce window, then a clean press.
      btn_mode = 1'b1; tick(2);
      btn_mode = 1'b0; tick(10);
      chk("glitch_pending", 28'(pending), 28'd0);
      btn_mode = 1'b1; tick(5);
      chk("press_pend_early", 28'(pending), 28'd0);
      tick();
      chk("press_pend_6", 28'(pending), 28'd1);
      chk("press_mode_hold", 28'(mode), 28'd0);
      tick(3);
      btn_mode = 1'b0; tick(8);
      frame();
      chk("ascii_mode", {25'd0, mode, filter_en}, 28'b011);
      chk("ascii_pending", 28'(pending), 28'd0);

      // Two colour presses in one frame give a single step.
      press_color(); press_color();
      frame();
      chk("amber_fg", 28'({fg_r, fg_g, fg_b}), 28'h0FA0);
      press_color();
      frame();
      chk("mono_fg", 28'({fg_r, fg_g, fg_b}), 28'h0FFF);

      // DEMO auto-step every third frame; a manual commit replaces the step.
      press_mode();
      frame();
      chk("demo_mode", 28'(mode), 28'd2);
      frame(); frame();
      chk("demo_no_step", 28'({fg_r, fg_g, fg_b}), 28'h0FFF);
      frame();
      chk("demo_auto_fg", 28'({fg_r, fg_g, fg_b}), 28'h00FF);
      chk("demo_auto_bg", 28'({bg_r, bg_g, bg_b}), 28'h0011);
      frame(); frame();
      press_color();
      frame();
      chk("demo_manual_single", 28'({fg_r, fg_g, fg_b}), 28'h00F0);
      frame(); frame();
      chk("demo_cnt_cleared", 28'({fg_r, fg_g, fg_b}), 28'h00F0);
      frame();
      chk("demo_auto_again", 28'({fg_r, fg_g, fg_b}), 28'h0FA0);

      // Press coincident with frame_start commits in that frame (DEMO -> PASS).
      btn_mode = 1'b1; tick(5);
      frame();
      chk("coinc_mode", {25'd0, mode, filter_en}, 28'b000);
      chk("coinc_pending", 28'(pending), 28'd0);
      chk("pass_keeps_pal", 28'({fg_r, fg_g, fg_b}), 28'h0FA0);
      tick(3);
      btn_mode = 1'b0; tick(8);

      // Colour press is ignored in PASS.
      press_color();
      chk("pass_color_pend", 28'(pending), 28'd0);
      frame();
      chk("pass_color_pal", 28'({fg_r, fg_g, fg_b}), 28'h0FA0);

      // Asynchronous reset with a change pending; button held through reset release.
      btn_mode = 1'b1; tick(6);
      chk("pre_reset_pend", 28'(pending), 28'd1);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_pend", 28'(pending), 28'd0);
      chk("async_rst_state", {mode, filter_en, fg_r, fg_g, fg_b, bg_r, bg_g, bg_b, pending},
          {2'd0, 1'b0, 24'h0F0010, 1'b0});
      tick(2);
      reset = 1'b0;
      tick(12);
      chk("held_no_press", 28'(pending), 28'd0);
      btn_mode = 1'b0; tick(8);
      chk("release_no_press", 28'(pending), 28'd0);
      btn_mode = 1'b1; tick(6);
      chk("repress_pend", 28'(pending), 28'd1);
      btn_mode = 1'b0; tick(8);
      frame();
      chk("repress_mode", 28'(mode), 28'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
